ecg_frame_reader: RTL

- Drains raw ECG samples from the SDP-BRAM ring (written by adc_if) and streams them frame-by-frame, with valid/ready, to dsp_if.
- Tracks ring occupancy from the write-enable pulses, fetches only complete ADS1298 frames (status word + 8 channels), and tags each word with its channel index.
- Detects ring overflow and resynchronises to a frame boundary. Sits between raw_ecg_ram and dsp_if, and owns the RAM read address.

---
 rtl/ecg_frame_reader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ecg_frame_reader.sv
// ecg_frame_reader: drains ADS1298 frames (status + 8 channels) from the raw ECG
// ring RAM and presents them one word at a time on a valid/ready stream.
// Owns the RAM read address, tracks ring occupancy from write-enable pulses,
// and on ring overflow drops back to the next frame boundary.
// Build option: define ECG_READER_STATUS_STRIP_EN to fetch but not present the
// status word (8 words per frame, m_sof on channel 1).
module ecg_frame_reader #(
  parameter int ADDR_W          = 9,
  parameter int DEPTH           = 504,
  parameter int WORDS_PER_FRAME = 9,
  parameter int DATA_W          = 24,
  parameter int RD_LAT          = 1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              enable,
  input  logic              ovf_clr,
  input  logic              ram_write_ce,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_chan,
  output logic              m_sof,
  output logic              m_eof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              ovf_sticky
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_RESYNC} state_t;

  localparam logic [3:0]        LAST_IDX = 4'(WORDS_PER_FRAME - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WPF_OCC  = (ADDR_W+1)'(WORDS_PER_FRAME);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);
`ifdef ECG_READER_STATUS_STRIP_EN
  localparam logic [3:0]        FIRST_IDX = 4'd1;
`else
  localparam logic [3:0]        FIRST_IDX = 4'd0;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W:0]     r_occ;
  logic [3:0]          r_wr_idx;
  logic [3:0]          r_rd_idx;
  logic [1:0]          r_lat_cnt;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_data;
  logic [3:0]          r_chan;
  logic                r_sof;
  logic                r_eof;

  logic                w_ovf;
  logic                w_wr_count;
  logic                w_start;
  logic                w_lat_done;
  logic                w_skip_word;
  logic                w_fetch;
  logic                w_capture;
  logic                w_accept;
  logic                w_valid;
  logic [ADDR_W-1:0]   w_rd_ptr_inc;
  logic [ADDR_W:0]     w_resync_sum;
  logic [ADDR_W:0]     w_resync_wide;
  logic                w_unused;

  // A write into a full ring lands on the oldest unread word.
  assign w_ovf = ram_write_ce && (r_occ == DEPTH_C);

  // While resynchronising, only writes that begin a fresh frame are counted.
  assign w_wr_count = ram_write_ce && !w_ovf &&
                      ((r_state != S_RESYNC) || (r_wr_idx == 4'd0));

  // New frames need a whole frame buffered and enable; a started frame only needs one word.
  assign w_start = (r_state == S_IDLE) &&
                   (((r_rd_idx == 4'd0) && enable && (r_occ >= WPF_OCC)) ||
                    ((r_rd_idx != 4'd0) && (r_occ != '0)));

  assign w_lat_done = (r_lat_cnt == LAT_LAST);

`ifdef ECG_READER_STATUS_STRIP_EN
  assign w_skip_word = (r_rd_idx == 4'd0);
`else
  assign w_skip_word = 1'b0;
`endif

  assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + ADDR_W'(1);

  // On overflow the current write sits at r_rd_ptr; skip to the start of the next frame.
  assign w_resync_sum  = {1'b0, r_rd_ptr} + WPF_OCC - (ADDR_W+1)'(r_wr_idx);
  assign w_resync_wide = (w_resync_sum >= DEPTH_C) ? w_resync_sum - DEPTH_C : w_resync_sum;

  assign w_unused = ^ram_rd_data[31:DATA_W];

  // State register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; overflow overrides every other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_WAIT;
      S_WAIT:   if (w_lat_done) w_state_next = w_skip_word ? S_IDLE : S_HOLD;
      S_HOLD:   if (m_ready) w_state_next = S_IDLE;
      S_RESYNC: if (r_wr_idx == 4'd0) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_ovf) w_state_next = S_RESYNC;
  end

  // Per-state control strobes; m_valid comes only from the state register
  always_comb begin
    w_fetch   = 1'b0;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    w_valid   = 1'b0;
    case (r_state)
      S_FETCH: w_fetch   = 1'b1;
      S_WAIT:  w_capture = w_lat_done && !w_ovf;
      S_HOLD: begin
        w_valid  = 1'b1;
        w_accept = m_ready && !w_ovf;
      end
      default: ;
    endcase
  end

  // Read pointer, presented address and occupancy bookkeeping
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rd_ptr  <= '0;
      r_rd_addr <= '0;
      r_occ     <= '0;
    end else if (w_ovf) begin
      r_rd_ptr <= w_resync_wide[ADDR_W-1:0];
      r_occ    <= '0;
    end else begin
      if (w_start) r_rd_addr <= r_rd_ptr;
      if (w_fetch) r_rd_ptr  <= w_rd_ptr_inc;
      case ({w_wr_count, w_fetch})
        2'b10:   r_occ <= r_occ + (ADDR_W+1)'(1);
        2'b01:   r_occ <= r_occ - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Writer's position inside its frame, advanced on every write
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)           r_wr_idx <= '0;
    else if (ram_write_ce) r_wr_idx <= (r_wr_idx == LAST_IDX) ? 4'd0 : r_wr_idx + 4'd1;
  end

  // Reader's position inside its frame; restarts at the status word after overflow
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     r_rd_idx <= '0;
    else if (w_ovf)  r_rd_idx <= '0;
    else if (w_accept || (w_capture && w_skip_word))
      r_rd_idx <= (r_rd_idx == LAST_IDX) ? 4'd0 : r_rd_idx + 4'd1;
  end

  // Counts RAM read latency cycles spent in WAIT
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                r_lat_cnt <= '0;
    else if (r_state != S_WAIT) r_lat_cnt <= '0;
    else if (!w_lat_done)       r_lat_cnt <= r_lat_cnt + 2'd1;
  end

  // Output word register, loaded once per presented word and held through HOLD
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_data <= '0;
      r_chan <= '0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
    end else if (w_capture && !w_skip_word) begin
      r_data <= ram_rd_data[DATA_W-1:0];
      r_chan <= r_rd_idx;
      r_sof  <= (r_rd_idx == FIRST_IDX);
      r_eof  <= (r_rd_idx == LAST_IDX);
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)      r_ovf <= 1'b0;
    else if (w_ovf)   r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign ram_rd_addr = r_rd_addr;
  assign m_data      = r_data;
  assign m_chan      = r_chan;
  assign m_sof       = r_sof;
  assign m_eof       = r_eof;
  assign m_valid     = w_valid;
  assign occupancy   = r_occ;
  assign ovf_sticky  = r_ovf;

endmodule
